// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM port signal bundle for ram_port_arbiter
interface ram_port_arbiter_if #(
  parameter int AW = 16
);
  logic          req0_i;
  logic [3:0]    we0_i;
  logic [AW-1:0] addr0_i;
  logic [31:0]   data0_i;
  logic          gnt0_o;
  logic          rvalid0_o;
  logic [31:0]   rdata0_o;

  logic          req1_i;
  logic [3:0]    we1_i;
  logic [AW-1:0] addr1_i;
  logic [31:0]   data1_i;
  logic          gnt1_o;
  logic          rvalid1_o;
  logic [31:0]   rdata1_o;

  logic          mem_en_o;
  logic [3:0]    mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_data_o;
  logic [31:0]   mem_data_i;
  logic [15:0]   conflict_cnt_o;

  modport slave (
    input  req0_i, we0_i, addr0_i, data0_i,
    output gnt0_o, rvalid0_o, rdata0_o,
    input  req1_i, we1_i, addr1_i, data1_i,
    output gnt1_o, rvalid1_o, rdata1_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
    input  mem_data_i,
    output conflict_cnt_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, data0_i,
    input  gnt0_o, rvalid0_o, rdata0_o,
    output req1_i, we1_i, addr1_i, data1_i,
    input  gnt1_o, rvalid1_o, rdata1_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
    output mem_data_i,
    input  conflict_cnt_o
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - fixed-priority RAM port arbiter with starvation guard for requester 1
module ram_port_arbiter #(
  parameter int MEM_WIDTH    = 65536,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             reset,
  ram_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(MEM_WIDTH);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        resp_pending_q, resp_pending_d;
  logic        resp_id_q, resp_id_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  logic        force1;
  logic        gnt0;
  logic        gnt1;
  logic [3:0]  sel_we;

  // Requester 0 wins unless requester 1 has been denied STARVE_LIMIT cycles in a row
  always_comb begin
    force1 = bus.req1_i && (wait_cnt_q == LIMIT);
    gnt1   = !reset && bus.req1_i && (!bus.req0_i || force1);
    gnt0   = !reset && bus.req0_i && !gnt1;
  end

  // Steer the granted requester onto the RAM port; idle port is driven to all zeros
  always_comb begin
    sel_we         = 4'b0;
    bus.mem_addr_o = AW'(0);
    bus.mem_data_o = 32'b0;
    if (gnt1) begin
      sel_we         = bus.we1_i;
      bus.mem_addr_o = bus.addr1_i;
      bus.mem_data_o = bus.data1_i;
    end else if (gnt0) begin
      sel_we         = bus.we0_i;
      bus.mem_addr_o = bus.addr0_i;
      bus.mem_data_o = bus.data0_i;
    end
    bus.mem_en_o = gnt0 || gnt1;
    bus.mem_we_o = sel_we;
    bus.gnt0_o   = gnt0;
    bus.gnt1_o   = gnt1;
  end

  // Next-state for the starvation counter, read-response tag and conflict counter
  always_comb begin
    wait_cnt_d = 8'd0;
    if (bus.req1_i && !gnt1) begin
      wait_cnt_d = (wait_cnt_q >= LIMIT) ? LIMIT : wait_cnt_q + 8'd1;
    end
    resp_pending_d = (gnt0 || gnt1) && (sel_we == 4'b0);
    resp_id_d      = gnt1;
    conflict_cnt_d = conflict_cnt_q;
    if (bus.req0_i && bus.req1_i && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // State registers; reset drops any read still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q     <= 8'd0;
      resp_pending_q <= 1'b0;
      resp_id_q      <= 1'b0;
      conflict_cnt_q <= 16'd0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      resp_pending_q <= resp_pending_d;
      resp_id_q      <= resp_id_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Route the registered RAM read data to whichever requester issued the read
  always_comb begin
    bus.rvalid0_o      = !reset && resp_pending_q && !resp_id_q;
    bus.rvalid1_o      = !reset && resp_pending_q && resp_id_q;
    bus.rdata0_o       = bus.rvalid0_o ? bus.mem_data_i : 32'b0;
    bus.rdata1_o       = bus.rvalid1_o ? bus.mem_data_i : 32'b0;
    bus.conflict_cnt_o = reset ? 16'd0 : conflict_cnt_q;
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
  localparam int MEM_WIDTH    = 65536;
  localparam int STARVE_LIMIT = 4;
  localparam int AW           = $clog2(MEM_WIDTH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW)) bus ();

  ram_port_arbiter #(.MEM_WIDTH(MEM_WIDTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Simulation RAM: byte-lane writes, one-cycle registered read
  bit [31:0] ram [16384];
  bit [31:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      ram_q <= ram[bus.mem_addr_o[15:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_o[b]) ram[bus.mem_addr_o[15:2]][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
    end
  end
  assign bus.mem_data_i = ram_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [3:0] w0, input logic [15:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1, input logic [15:0] a1, input logic [31:0] d1);
    bus.req0_i = r0; bus.we0_i = w0; bus.addr0_i = a0; bus.data0_i = d0;
    bus.req1_i = r1; bus.we1_i = w1; bus.addr1_i = a1; bus.data1_i = d1;
  endtask

  task automatic idle();
    drive(0, 4'h0, 16'h0, 32'h0, 0, 4'h0, 16'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic r0; logic [3:0] w0; logic [15:0] a0; logic [31:0] d0;
    logic r1; logic [3:0] w1; logic [15:0] a1; logic [31:0] d1;
    logic g0; logic g1; logic [3:0] mwe; logic [15:0] maddr; logic [31:0] mdata;
    logic rv0; logic rv1;
  } vec_t;

  vec_t vecs [7];

  // Random-phase reference model state
  bit [31:0] shadow [16384];
  int        streak;
  int        conflicts;
  bit        pend_v, pend_id;
  bit [31:0] pend_d;
  bit        act0, act1;
  bit [3:0]  rw0, rw1;
  bit [15:0] ra0, ra1;
  bit [31:0] rd0, rd1;
  bit        eg0, eg1;

  initial begin
    logic exp_ord [10];
    exp_ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    vecs[0] = '{1, 4'h0, 16'h0100, 32'h0,        0, 4'h0, 16'h0,    32'h0,        1, 0, 4'h0, 16'h0100, 32'h0,        0, 0};
    vecs[1] = '{0, 4'h0, 16'h0,    32'h0,        1, 4'h3, 16'h0200, 32'h12345678, 0, 1, 4'h3, 16'h0200, 32'h12345678, 1, 0};
    vecs[2] = '{0, 4'h0, 16'h0,    32'h0,        0, 4'h0, 16'h0,    32'h0,        0, 0, 4'h0, 16'h0,    32'h0,        0, 0};
    vecs[3] = '{1, 4'hF, 16'h0010, 32'hAAAA5555, 1, 4'h0, 16'h0020, 32'h0,        1, 0, 4'hF, 16'h0010, 32'hAAAA5555, 0, 0};
    vecs[4] = '{1, 4'h0, 16'h0010, 32'h0,        0, 4'h0, 16'h0,    32'h0,        1, 0, 4'h0, 16'h0010, 32'h0,        0, 0};
    vecs[5] = '{0, 4'h0, 16'h0,    32'h0,        1, 4'h0, 16'h0200, 32'h55,       0, 1, 4'h0, 16'h0200, 32'h55,       1, 0};
    vecs[6] = '{0, 4'h5, 16'h3333, 32'hFFFF0000, 0, 4'hA, 16'h4444, 32'h1,        0, 0, 4'h0, 16'h0,    32'h0,        0, 1};

    // Reset with both requesting: everything held at zero
    reset = 1'b1;
    drive(1, 4'h0, 16'h0100, 32'h1, 1, 4'h0, 16'h0200, 32'h2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gnt", {bus.gnt0_o, bus.gnt1_o, bus.mem_en_o, bus.mem_we_o}, 32'h0);
      check("rst_rvalid", {bus.rvalid0_o, bus.rvalid1_o}, 32'h0);
      check("rst_rdata", bus.rdata0_o | bus.rdata1_o, 32'h0);
      check("rst_conflict", bus.conflict_cnt_o, 32'h0);
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_conflict", bus.conflict_cnt_o, 32'h0);
    check("post_rst_gnt0", bus.gnt0_o, 1);
    tick();

    // Preload then lone read by requester 0
    drive(1, 4'hF, 16'h0100, 32'hDEADBEEF, 0, 4'h0, 16'h0, 32'h0);
    tick();
    drive(1, 4'h0, 16'h0100, 32'h0, 0, 4'h0, 16'h0, 32'h0);
    @(negedge clk);
    check("read_gnt0", {bus.gnt0_o, bus.gnt1_o}, 32'h2);
    tick();
    idle();
    @(negedge clk);
    check("read_rvalid0", bus.rvalid0_o, 1);
    check("read_rdata0", bus.rdata0_o, 32'hDEADBEEF);
    check("read_rvalid1", bus.rvalid1_o, 0);
    tick();

    // Lone write by requester 1
    drive(0, 4'h0, 16'h0, 32'h0, 1, 4'h3, 16'h0200, 32'h12345678);
    @(negedge clk);
    check("write_en", bus.mem_en_o, 1);
    check("write_we", bus.mem_we_o, 4'h3);
    check("write_addr", bus.mem_addr_o, 16'h0200);
    check("write_data", bus.mem_data_o, 32'h12345678);
    tick();
    idle();
    @(negedge clk);
    check("write_no_rvalid", {bus.rvalid0_o, bus.rvalid1_o}, 32'h0);
    tick();

    // Table of single-cycle vectors
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), {bus.gnt0_o, bus.gnt1_o}, {vecs[i].g0, vecs[i].g1});
      check($sformatf("vec%0d_en", i), bus.mem_en_o, vecs[i].g0 | vecs[i].g1);
      check($sformatf("vec%0d_we", i), bus.mem_we_o, vecs[i].mwe);
      check($sformatf("vec%0d_addr", i), bus.mem_addr_o, vecs[i].maddr);
      check($sformatf("vec%0d_data", i), bus.mem_data_o, vecs[i].mdata);
      check($sformatf("vec%0d_rvalid", i), {bus.rvalid0_o, bus.rvalid1_o}, {vecs[i].rv0, vecs[i].rv1});
      tick();
    end
    idle();

    // Contention: both read continuously for 10 cycles
    do_reset(2);
    drive(1, 4'h0, 16'h0100, 32'h0, 1, 4'h0, 16'h0200, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("cont%0d_gnt", i), {bus.gnt0_o, bus.gnt1_o}, {!exp_ord[i], exp_ord[i]});
      if (i > 0) begin
        check($sformatf("cont%0d_rvalid", i), {bus.rvalid0_o, bus.rvalid1_o}, {!exp_ord[i-1], exp_ord[i-1]});
        check($sformatf("cont%0d_rdata", i), exp_ord[i-1] ? bus.rdata1_o : bus.rdata0_o,
              exp_ord[i-1] ? 32'h00005678 : 32'hDEADBEEF);
      end
      tick();
    end
    idle();
    @(negedge clk);
    check("cont_last_rvalid1", bus.rvalid1_o, 1);
    check("cont_conflict", bus.conflict_cnt_o, 32'd10);
    tick();

    // Dropping req1 restarts its wait count
    for (int i = 0; i < 9; i++) begin
      drive(1, 4'h0, 16'h0100, 32'h0, (i != 3), 4'h0, 16'h0200, 32'h0);
      @(negedge clk);
      check($sformatf("wait%0d_gnt", i), {bus.gnt0_o, bus.gnt1_o}, (i == 8) ? 32'h1 : 32'h2);
      tick();
    end
    idle();
    tick();

    // Reset arriving one cycle after a requester 1 read grant
    drive(0, 4'h0, 16'h0, 32'h0, 1, 4'h0, 16'h0200, 32'h0);
    @(negedge clk);
    check("rstmid_gnt1", bus.gnt1_o, 1);
    tick();
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_rvalid_n1", {bus.rvalid0_o, bus.rvalid1_o}, 32'h0);
    check("rstmid_rdata_n1", bus.rdata1_o, 32'h0);
    tick();
    @(negedge clk);
    check("rstmid_rvalid_n2", {bus.rvalid0_o, bus.rvalid1_o}, 32'h0);
    check("rstmid_outs", {bus.gnt0_o, bus.gnt1_o, bus.mem_en_o, bus.mem_we_o, bus.conflict_cnt_o}, 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_after", {bus.rvalid0_o, bus.rvalid1_o}, 32'h0);
    tick();

    // Randomized traffic against a transaction-level model
    do_reset(2);
    streak = 0; conflicts = 0; pend_v = 0; pend_id = 0; pend_d = 0; act0 = 0; act1 = 0;
    for (int c = 0; c < 500; c++) begin
      if (!act0) begin
        act0 = ($urandom % 10) < 6;
        rw0  = ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15));
        ra0  = 16'h1000 + 16'($urandom_range(0, 15) * 4);
        rd0  = $urandom;
      end
      if (!act1) begin
        act1 = ($urandom % 10) < 6;
        rw1  = ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15));
        ra1  = 16'h1000 + 16'($urandom_range(0, 15) * 4);
        rd1  = $urandom;
      end
      drive(act0, rw0, ra0, rd0, act1, rw1, ra1, rd1);
      eg1 = act1 && (!act0 || streak == STARVE_LIMIT);
      eg0 = act0 && !eg1;
      @(negedge clk);
      check("rnd_gnt", {bus.gnt0_o, bus.gnt1_o}, {eg0, eg1});
      check("rnd_en", bus.mem_en_o, eg0 | eg1);
      check("rnd_addr", bus.mem_addr_o, eg1 ? ra1 : (eg0 ? ra0 : 16'h0));
      check("rnd_we", bus.mem_we_o, eg1 ? rw1 : (eg0 ? rw0 : 4'h0));
      check("rnd_rvalid", {bus.rvalid0_o, bus.rvalid1_o}, {pend_v && !pend_id, pend_v && pend_id});
      check("rnd_rdata0", bus.rdata0_o, (pend_v && !pend_id) ? pend_d : 32'h0);
      check("rnd_rdata1", bus.rdata1_o, (pend_v && pend_id) ? pend_d : 32'h0);
      pend_v = 0;
      if (eg0 || eg1) begin
        bit [3:0]  w;
        bit [15:0] a;
        bit [31:0] d;
        w = eg1 ? rw1 : rw0;
        a = eg1 ? ra1 : ra0;
        d = eg1 ? rd1 : rd0;
        pend_v  = (w == 4'h0);
        pend_id = eg1;
        pend_d  = shadow[a[15:2]];
        for (int b = 0; b < 4; b++)
          if (w[b]) shadow[a[15:2]][8*b +: 8] = d[8*b +: 8];
      end
      if (act1 && !eg1) streak = (streak < STARVE_LIMIT) ? streak + 1 : STARVE_LIMIT;
      else streak = 0;
      if (act0 && act1) conflicts++;
      if (eg0) act0 = 0;
      if (eg1) act1 = 0;
      tick();
    end
    idle();
    @(negedge clk);
    check("rnd_conflict", bus.conflict_cnt_o, 32'(conflicts));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter that shares one port of the dual-port byte-addressed simulation RAM (32-bit data, byte-lane write enables, 1-cycle registered read).
- Requester 0 is the core data bus and has fixed priority. Requester 1 is a DMA/peripheral master.
- A starvation counter guarantees requester 1 a grant after a bounded wait.
- The block routes each read response back to the requester that issued it.

Parameters:
- MEM_WIDTH, 65536, RAM size in bytes; address width is $clog2(MEM_WIDTH).
- STARVE_LIMIT, 4, consecutive denied cycles of requester 1 before it is force-granted; range 1..255.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req0_i  input  1  requester 0 access request
- we0_i  input  4  requester 0 byte write enables; 0 = read
- addr0_i  input  AW  requester 0 byte address
- data0_i  input  32  requester 0 write data
- gnt0_o  output  1  requester 0 granted this cycle
- rvalid0_o  output  1  read data valid for requester 0
- rdata0_o  output  32  read data for requester 0
- req1_i, we1_i, addr1_i, data1_i, gnt1_o, rvalid1_o, rdata1_o: same as the requester 0 ports, for requester 1
- mem_en_o  output  1  RAM port enable
- mem_we_o  output  4  RAM byte write enables
- mem_addr_o  output  AW  RAM address
- mem_data_o  output  32  RAM write data
- mem_data_i  input  32  RAM registered read data
- conflict_cnt_o  output  16  saturating count of cycles in which both requesters asserted req

Behaviour:
- **Arbitration** (combinational within the cycle, from the current requests and the wait_cnt register):
  - force1 = req1_i and (wait_cnt == STARVE_LIMIT).
  - gnt1_o = req1_i and (not req0_i or force1).
  - gnt0_o = req0_i and not gnt1_o.
  - At most one grant is high. No grant is issued while reset is high.
- **RAM drive:**
  - mem_en_o = gnt0_o or gnt1_o.
  - mem_we_o, mem_addr_o and mem_data_o carry the granted requester's we/addr/data.
  - When no requester is granted, mem_we_o = 0, mem_addr_o = 0 and mem_data_o = 0.
  - The RAM samples on the same clk edge that ends the grant cycle.
- **Handshake:**
  - A request is consumed in the cycle its gnt is high.
  - A requester holds req/we/addr/data stable until granted; the arbiter does not check this.
  - Back-to-back grants to the same requester are allowed every cycle.
- **Read response:**
  - Registered state: resp_pending (1 bit) and resp_id (1 bit).
  - These are set on the clock edge ending a grant cycle with we == 0, with resp_id = the granted index. Otherwise resp_pending clears.
  - In the following cycle, rvalidN_o = resp_pending and (resp_id == N).
  - rdataN_o = mem_data_i when rvalidN_o is high, else 0.
  - Read latency is exactly 1 cycle after grant. A write produces no rvalid.
- **Starvation counter** wait_cnt (8 bits):
  - Increments when req1_i = 1 and gnt1_o = 0, saturating at STARVE_LIMIT.
  - Clears when gnt1_o = 1 or req1_i = 0.
- **conflict_cnt_o:** increments on every cycle with req0_i and req1_i both high; saturates at 16'hFFFF.
- **Reset values:** gnt0/1_o = 0, rvalid0/1_o = 0, rdata0/1_o = 0, mem_en_o = 0, mem_we_o = 0, wait_cnt = 0, resp_pending = 0, conflict_cnt_o = 0.
- **Reset mid-operation:** a read granted in the cycle before reset asserts is dropped, and no rvalid appears in the cycle after reset.
- **Simultaneous events:**
  - When force1 is true, req0 is stalled for that cycle only, even if req0 has been waiting.
  - A requester 1 write granted by force also clears wait_cnt.
- **Address:** passed through unchanged; no alignment or bounds check.

Test Plan:
1. Reset sequence: hold reset 3 cycles with req0_i = req1_i = 1 -> every output 0 during reset; conflict_cnt_o = 0 on the first cycle after release.
2. Lone read: req0 with we0 = 0, addr0 = 16'h0100, RAM word 32'hDEADBEEF -> gnt0_o high in cycle N; rvalid0_o = 1 and rdata0_o = 32'hDEADBEEF in N+1; rvalid1_o = 0.
3. Lone write: req1 with we1 = 4'b0011, addr1 = 16'h0200, data1 = 32'h12345678 -> mem_en_o = 1, mem_we_o = 4'b0011, mem_data_o = 32'h12345678 in the grant cycle; no rvalid in the next cycle.
4. Contention, STARVE_LIMIT = 4: both requesters assert reads continuously for 10 cycles -> grant order 0,0,0,0,1,0,0,0,0,1; each rvalid follows its grant by 1 cycle to the matching requester; conflict_cnt_o = 10.
5. Wait reset: req1 held while req0 is high for 3 cycles, then req1 drops for 1 cycle and reasserts -> wait_cnt restarts at 0, and requester 1 needs 4 more denied cycles before its forced grant.
6. Reset mid-read: requester 1 read granted in cycle N, reset asserted in N+1 -> rvalid1_o = 0 in N+1 and N+2; outputs return to reset values.
